// File: rtl/audio_gain_stage.sv
// rtl/audio_gain_stage.sv - stereo serial shift-add gain stage with saturation
module audio_gain_stage #(
   parameter int GAIN_W = 8,
   parameter int FRAC   = 6
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              LRCK,
   input  logic [23:0]       LCH_ADC,
   input  logic [23:0]       RCH_ADC,
   input  logic [GAIN_W-1:0] gain_l,
   input  logic [GAIN_W-1:0] gain_r,
   input  logic              mute,
   output logic [23:0]       LCH_DAC,
   output logic [23:0]       RCH_DAC,
   output logic              sample_stb,
   output logic              clip_l,
   output logic              clip_r,
   output logic              busy,
   output logic              overrun
);

   // Accumulator holds the full signed product of a 24-bit sample and an unsigned gain.
   localparam int ACC_W = 24 + GAIN_W + 1;
   localparam int CNT_W = (GAIN_W > 1) ? $clog2(GAIN_W) : 1;

   typedef enum logic [2:0] {
      S_IDLE,
      S_MUL_L,
      S_MUL_R,
      S_SAT,
      S_OUT
   } state_t;

   state_t r_state;
   state_t w_next;

   logic                     r_lrck_d;
   logic [23:0]              r_samp_r;
   logic [GAIN_W-1:0]        r_gain_r;
   logic                     r_mute;
   logic signed [ACC_W-1:0]  r_mcand;
   logic [GAIN_W-1:0]        r_mplier;
   logic signed [ACC_W-1:0]  r_acc;
   logic [CNT_W-1:0]         r_bit_cnt;
   logic signed [ACC_W-1:0]  r_prod_l;
   logic signed [ACC_W-1:0]  r_prod_r;
   logic [23:0]              r_sat_l;
   logic [23:0]              r_sat_r;
   logic                     r_ovf_l;
   logic                     r_ovf_r;
   logic [23:0]              r_lch;
   logic [23:0]              r_rch;
   logic                     r_stb;
   logic                     r_clip_l;
   logic                     r_clip_r;
   logic                     r_busy;
   logic                     r_overrun;

   logic                     w_frame_edge;
   logic                     w_last_bit;
   logic signed [ACC_W-1:0]  w_acc_sum;
   logic signed [ACC_W-1:0]  w_shr_l;
   logic signed [ACC_W-1:0]  w_shr_r;
   logic                     w_fits_l;
   logic                     w_fits_r;
   logic [23:0]              w_sat_l;
   logic [23:0]              w_sat_r;

   assign w_frame_edge = LRCK & ~r_lrck_d;
   assign w_last_bit   = (r_bit_cnt == CNT_W'(GAIN_W - 1));
   assign w_acc_sum    = r_acc + (r_mplier[0] ? r_mcand : '0);

   // Floor-shift the products; a result fits in 24 bits when all bits above bit 23 match the sign.
   assign w_shr_l  = r_prod_l >>> FRAC;
   assign w_shr_r  = r_prod_r >>> FRAC;
   assign w_fits_l = (&w_shr_l[ACC_W-1:23]) | ~(|w_shr_l[ACC_W-1:23]);
   assign w_fits_r = (&w_shr_r[ACC_W-1:23]) | ~(|w_shr_r[ACC_W-1:23]);
   assign w_sat_l  = w_fits_l ? w_shr_l[23:0] : (w_shr_l[ACC_W-1] ? 24'h800000 : 24'h7FFFFF);
   assign w_sat_r  = w_fits_r ? w_shr_r[23:0] : (w_shr_r[ACC_W-1] ? 24'h800000 : 24'h7FFFFF);

   assign LCH_DAC    = r_lch;
   assign RCH_DAC    = r_rch;
   assign sample_stb = r_stb;
   assign clip_l     = r_clip_l;
   assign clip_r     = r_clip_r;
   assign busy       = r_busy;
   assign overrun    = r_overrun;

   // State register.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   // Next-state logic: one frame walks IDLE -> MUL_L -> MUL_R -> SAT -> OUT -> IDLE.
   always_comb begin
      w_next = r_state;
      case (r_state)
         S_IDLE:  if (w_frame_edge) w_next = S_MUL_L;
         S_MUL_L: if (w_last_bit)   w_next = S_MUL_R;
         S_MUL_R: if (w_last_bit)   w_next = S_SAT;
         S_SAT:   w_next = S_OUT;
         S_OUT:   w_next = S_IDLE;
         default: w_next = S_IDLE;
      endcase
   end

   // Datapath: capture, LSB-first shift-add multiply, saturate, then publish results.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_lrck_d  <= 1'b1;
         r_samp_r  <= '0;
         r_gain_r  <= '0;
         r_mute    <= 1'b0;
         r_mcand   <= '0;
         r_mplier  <= '0;
         r_acc     <= '0;
         r_bit_cnt <= '0;
         r_prod_l  <= '0;
         r_prod_r  <= '0;
         r_sat_l   <= '0;
         r_sat_r   <= '0;
         r_ovf_l   <= 1'b0;
         r_ovf_r   <= 1'b0;
         r_lch     <= '0;
         r_rch     <= '0;
         r_stb     <= 1'b0;
         r_clip_l  <= 1'b0;
         r_clip_r  <= 1'b0;
         r_busy    <= 1'b0;
         r_overrun <= 1'b0;
      end else begin
         r_lrck_d <= LRCK;
         r_stb    <= 1'b0;
         if (w_frame_edge && (r_state != S_IDLE)) begin
            r_overrun <= 1'b1;
         end
         case (r_state)
            S_IDLE: begin
               if (w_frame_edge) begin
                  r_samp_r  <= RCH_ADC;
                  r_gain_r  <= gain_r;
                  r_mute    <= mute;
                  r_mcand   <= {{(ACC_W-24){LCH_ADC[23]}}, LCH_ADC};
                  r_mplier  <= gain_l;
                  r_acc     <= '0;
                  r_bit_cnt <= '0;
                  r_busy    <= 1'b1;
               end
            end
            S_MUL_L: begin
               r_acc     <= w_acc_sum;
               r_mcand   <= r_mcand << 1;
               r_mplier  <= r_mplier >> 1;
               r_bit_cnt <= r_bit_cnt + CNT_W'(1);
               if (w_last_bit) begin
                  r_prod_l  <= w_acc_sum;
                  r_acc     <= '0;
                  r_mcand   <= {{(ACC_W-24){r_samp_r[23]}}, r_samp_r};
                  r_mplier  <= r_gain_r;
                  r_bit_cnt <= '0;
               end
            end
            S_MUL_R: begin
               r_acc     <= w_acc_sum;
               r_mcand   <= r_mcand << 1;
               r_mplier  <= r_mplier >> 1;
               r_bit_cnt <= r_bit_cnt + CNT_W'(1);
               if (w_last_bit) begin
                  r_prod_r  <= w_acc_sum;
                  r_bit_cnt <= '0;
               end
            end
            S_SAT: begin
               r_sat_l <= w_sat_l;
               r_sat_r <= w_sat_r;
               r_ovf_l <= ~w_fits_l;
               r_ovf_r <= ~w_fits_r;
            end
            S_OUT: begin
               r_lch    <= r_mute ? 24'h0 : r_sat_l;
               r_rch    <= r_mute ? 24'h0 : r_sat_r;
               r_clip_l <= r_mute ? 1'b0 : r_ovf_l;
               r_clip_r <= r_mute ? 1'b0 : r_ovf_r;
               r_stb    <= 1'b1;
               r_busy   <= 1'b0;
            end
            default: begin
               r_busy <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_audio_gain_stage.sv
// tb/tb_audio_gain_stage.sv - self-checking bench for audio_gain_stage
module tb_audio_gain_stage;

   logic        clk = 1'b0;
   logic        rst;
   logic        LRCK;
   logic [23:0] LCH_ADC;
   logic [23:0] RCH_ADC;
   logic [7:0]  gain_l;
   logic [7:0]  gain_r;
   logic        mute;
   logic [23:0] LCH_DAC;
   logic [23:0] RCH_DAC;
   logic        sample_stb;
   logic        clip_l;
   logic        clip_r;
   logic        busy;
   logic        overrun;

   int errors = 0;
   int checks = 0;

   audio_gain_stage #(.GAIN_W(8), .FRAC(6)) dut (
      .clk(clk), .rst(rst), .LRCK(LRCK),
      .LCH_ADC(LCH_ADC), .RCH_ADC(RCH_ADC),
      .gain_l(gain_l), .gain_r(gain_r), .mute(mute),
      .LCH_DAC(LCH_DAC), .RCH_DAC(RCH_DAC), .sample_stb(sample_stb),
      .clip_l(clip_l), .clip_r(clip_r), .busy(busy), .overrun(overrun)
   );

   always #5 clk = ~clk;

   // Reference: {clip, value} from plain integer arithmetic.
   function automatic logic [24:0] model(input logic [23:0] s, input logic [7:0] g, input logic m);
      longint p;
      longint r;
      logic [63:0] rv;
      p = longint'($signed(s)) * longint'(g);
      r = p >>> 6;
      rv = r;
      if (m) return 25'h0;
      if (r > 64'sd8388607) return {1'b1, 24'h7FFFFF};
      if (r < -64'sd8388608) return {1'b1, 24'h800000};
      return {1'b0, rv[23:0]};
   endfunction

   // Runs one frame; inputs are scrambled right after capture to prove they are latched.
   task automatic do_frame(input logic [23:0] l, input logic [23:0] r,
                           input logic [7:0] gl, input logic [7:0] gr, input logic m,
                           output int stb_edge, output int stb_cnt,
                           output logic busy0, output logic busy19);
      @(negedge clk);
      LRCK = 1'b0;
      @(negedge clk);
      LCH_ADC = l; RCH_ADC = r; gain_l = gl; gain_r = gr; mute = m;
      LRCK = 1'b1;
      stb_edge = -1; stb_cnt = 0; busy0 = 1'b0; busy19 = 1'b1;
      for (int n = 0; n < 26; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (sample_stb) begin
            stb_cnt++;
            if (stb_edge < 0) stb_edge = n;
         end
         if (n == 0) begin
            busy0 = busy;
            LCH_ADC = 24'($urandom); RCH_ADC = 24'($urandom);
            gain_l = 8'($urandom); gain_r = 8'($urandom); mute = ~m;
         end
         if (n == 19) busy19 = busy;
      end
      LRCK = 1'b0;
   endtask

   task automatic test_reset;
      int stb_seen;
      rst = 1'b1; LRCK = 1'b1; LCH_ADC = 24'h123456; RCH_ADC = 24'h654321;
      gain_l = 8'd64; gain_r = 8'd64; mute = 1'b0;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (LCH_DAC !== 24'h0) begin errors++; $display("FAIL reset_lch: got %h want 000000", LCH_DAC); end
      checks++; if (RCH_DAC !== 24'h0) begin errors++; $display("FAIL reset_rch: got %h want 000000", RCH_DAC); end
      checks++; if ({sample_stb, clip_l, clip_r, busy, overrun} !== 5'b0) begin
         errors++; $display("FAIL reset_flags: got %b want 00000", {sample_stb, clip_l, clip_r, busy, overrun});
      end
      rst = 1'b0;
      stb_seen = 0;
      for (int n = 0; n < 25; n++) begin
         @(negedge clk);
         if (busy || sample_stb) stb_seen++;
      end
      checks++; if (stb_seen !== 0) begin errors++; $display("FAIL lrck_high_after_reset: got %0d active cycles want 0", stb_seen); end
   endtask

   task automatic test_unity;
      int e, c; logic b0, b19;
      do_frame(24'h123456, 24'hFEDCBA, 8'd64, 8'd64, 1'b0, e, c, b0, b19);
      checks++; if (e !== 18) begin errors++; $display("FAIL unity_stb_edge: got %0d want 18", e); end
      checks++; if (c !== 1) begin errors++; $display("FAIL unity_stb_count: got %0d want 1", c); end
      checks++; if (LCH_DAC !== 24'h123456) begin errors++; $display("FAIL unity_lch: got %h want 123456", LCH_DAC); end
      checks++; if (RCH_DAC !== 24'hFEDCBA) begin errors++; $display("FAIL unity_rch: got %h want fedcba", RCH_DAC); end
      checks++; if ({clip_l, clip_r} !== 2'b00) begin errors++; $display("FAIL unity_clip: got %b want 00", {clip_l, clip_r}); end
      checks++; if (b0 !== 1'b1) begin errors++; $display("FAIL unity_busy_edge0: got %b want 1", b0); end
      checks++; if (b19 !== 1'b0) begin errors++; $display("FAIL unity_busy_edge19: got %b want 0", b19); end
   endtask

   task automatic test_saturation;
      int e, c; logic b0, b19;
      do_frame(24'h500000, 24'hB00000, 8'd128, 8'd128, 1'b0, e, c, b0, b19);
      checks++; if (LCH_DAC !== 24'h7FFFFF) begin errors++; $display("FAIL sat_pos: got %h want 7fffff", LCH_DAC); end
      checks++; if (RCH_DAC !== 24'h800000) begin errors++; $display("FAIL sat_neg: got %h want 800000", RCH_DAC); end
      checks++; if ({clip_l, clip_r} !== 2'b11) begin errors++; $display("FAIL sat_clip: got %b want 11", {clip_l, clip_r}); end
      do_frame(24'h000010, 24'h000010, 8'd64, 8'd64, 1'b0, e, c, b0, b19);
      checks++; if (LCH_DAC !== 24'h000010) begin errors++; $display("FAIL sat_recover: got %h want 000010", LCH_DAC); end
      checks++; if (clip_l !== 1'b0) begin errors++; $display("FAIL sat_clip_clear: got %b want 0", clip_l); end
   endtask

   task automatic test_rounding;
      int e, c; logic b0, b19;
      do_frame(24'hFFFFFF, 24'h000003, 8'd32, 8'd32, 1'b0, e, c, b0, b19);
      checks++; if (LCH_DAC !== 24'hFFFFFF) begin errors++; $display("FAIL floor_neg: got %h want ffffff", LCH_DAC); end
      checks++; if (RCH_DAC !== 24'h000001) begin errors++; $display("FAIL floor_pos: got %h want 000001", RCH_DAC); end
      do_frame(24'h7FFFFF, 24'h000000, 8'd255, 8'd0, 1'b0, e, c, b0, b19);
      checks++; if (LCH_DAC !== 24'h7FFFFF || clip_l !== 1'b1) begin
         errors++; $display("FAIL max_gain: got %h/%b want 7fffff/1", LCH_DAC, clip_l);
      end
   endtask

   task automatic test_zero_and_mute;
      int e, c; logic b0, b19;
      do_frame(24'h400000, 24'h000100, 8'd0, 8'd64, 1'b0, e, c, b0, b19);
      checks++; if (LCH_DAC !== 24'h0 || clip_l !== 1'b0) begin
         errors++; $display("FAIL gain_zero: got %h/%b want 000000/0", LCH_DAC, clip_l);
      end
      checks++; if (RCH_DAC !== 24'h000100) begin errors++; $display("FAIL gain_zero_r: got %h want 000100", RCH_DAC); end
      do_frame(24'h123456, 24'h7FFFFF, 8'd64, 8'd255, 1'b1, e, c, b0, b19);
      checks++; if ({LCH_DAC, RCH_DAC} !== 48'h0 || {clip_l, clip_r} !== 2'b00) begin
         errors++; $display("FAIL mute: got %h %h %b%b want 0 0 00", LCH_DAC, RCH_DAC, clip_l, clip_r);
      end
      checks++; if (e !== 18 || c !== 1) begin errors++; $display("FAIL mute_stb: got edge %0d count %0d want 18 1", e, c); end
   endtask

   task automatic test_random;
      int e, c; logic b0, b19;
      logic [23:0] l, r; logic [7:0] gl, gr; logic m;
      logic [24:0] exp_l, exp_r;
      for (int k = 0; k < 16; k++) begin
         l = 24'($urandom); r = 24'($urandom);
         gl = 8'($urandom); gr = 8'($urandom);
         m = ($urandom_range(0, 7) == 0);
         exp_l = model(l, gl, m);
         exp_r = model(r, gr, m);
         do_frame(l, r, gl, gr, m, e, c, b0, b19);
         checks++; if (LCH_DAC !== exp_l[23:0] || clip_l !== exp_l[24]) begin
            errors++; $display("FAIL rand_l[%0d]: got %h/%b want %h/%b (s=%h g=%0d m=%b)", k, LCH_DAC, clip_l, exp_l[23:0], exp_l[24], l, gl, m);
         end
         checks++; if (RCH_DAC !== exp_r[23:0] || clip_r !== exp_r[24]) begin
            errors++; $display("FAIL rand_r[%0d]: got %h/%b want %h/%b (s=%h g=%0d m=%b)", k, RCH_DAC, clip_r, exp_r[23:0], exp_r[24], r, gr, m);
         end
         checks++; if (e !== 18 || c !== 1) begin errors++; $display("FAIL rand_stb[%0d]: got edge %0d count %0d want 18 1", k, e, c); end
      end
   endtask

   task automatic test_edge_at_out;
      int c, e; logic b0, b19, bz;
      @(negedge clk);
      LRCK = 1'b0;
      @(negedge clk);
      LCH_ADC = 24'h000200; RCH_ADC = 24'h000300; gain_l = 8'd64; gain_r = 8'd64; mute = 1'b0;
      LRCK = 1'b1;
      c = 0; bz = 1'b1;
      for (int n = 0; n < 40; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (sample_stb) c++;
         if (n == 16) LRCK = 1'b0;
         if (n == 17) LRCK = 1'b1;
         if (n == 19) bz = busy;
      end
      LRCK = 1'b0;
      checks++; if (c !== 1) begin errors++; $display("FAIL out_edge_stb_count: got %0d want 1", c); end
      checks++; if (bz !== 1'b0) begin errors++; $display("FAIL out_edge_ignored: got busy %b want 0", bz); end
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL out_edge_overrun: got %b want 1", overrun); end
      checks++; if (LCH_DAC !== 24'h000200) begin errors++; $display("FAIL out_edge_lch: got %h want 000200", LCH_DAC); end
      do_frame(24'h000020, 24'h000040, 8'd64, 8'd64, 1'b0, e, c, b0, b19);
      checks++; if (e !== 18 || RCH_DAC !== 24'h000040) begin
         errors++; $display("FAIL after_out_edge: got edge %0d rch %h want 18 000040", e, RCH_DAC);
      end
   endtask

   task automatic test_reset_mid_frame;
      int c, e; logic b0, b19;
      @(negedge clk);
      LRCK = 1'b0;
      @(negedge clk);
      LCH_ADC = 24'h111111; RCH_ADC = 24'h222222; gain_l = 8'd64; gain_r = 8'd64; mute = 1'b0;
      LRCK = 1'b1;
      for (int n = 0; n < 10; n++) begin
         @(posedge clk);
         @(negedge clk);
      end
      rst = 1'b1;
      @(posedge clk);
      @(negedge clk);
      checks++; if ({LCH_DAC, RCH_DAC} !== 48'h0) begin errors++; $display("FAIL rst_mid_out: got %h %h want 0 0", LCH_DAC, RCH_DAC); end
      checks++; if ({sample_stb, busy, overrun} !== 3'b000) begin
         errors++; $display("FAIL rst_mid_flags: got %b want 000", {sample_stb, busy, overrun});
      end
      rst = 1'b0;
      c = 0;
      for (int n = 0; n < 25; n++) begin
         @(negedge clk);
         if (sample_stb) c++;
      end
      checks++; if (c !== 0) begin errors++; $display("FAIL rst_mid_no_stb: got %0d want 0", c); end
      do_frame(24'h000100, 24'h000000, 8'd64, 8'd64, 1'b0, e, c, b0, b19);
      checks++; if (e !== 18 || LCH_DAC !== 24'h000100) begin
         errors++; $display("FAIL rst_mid_next: got edge %0d lch %h want 18 000100", e, LCH_DAC);
      end
   endtask

   task automatic test_overrun;
      int c, e, ee; logic b0, b19, ov8;
      @(negedge clk);
      LRCK = 1'b0;
      @(negedge clk);
      LCH_ADC = 24'h000040; RCH_ADC = 24'h000080; gain_l = 8'd64; gain_r = 8'd64; mute = 1'b0;
      LRCK = 1'b1;
      c = 0; ee = -1; ov8 = 1'b0;
      for (int n = 0; n < 30; n++) begin
         @(posedge clk);
         @(negedge clk);
         if (sample_stb) begin
            c++;
            if (ee < 0) ee = n;
         end
         if (n == 3) begin gain_l = 8'd0; LCH_ADC = 24'h7FFFFF; end
         if (n == 6) LRCK = 1'b0;
         if (n == 7) LRCK = 1'b1;
         if (n == 8) ov8 = overrun;
      end
      LRCK = 1'b0;
      checks++; if (ov8 !== 1'b1) begin errors++; $display("FAIL overrun_set: got %b want 1", ov8); end
      checks++; if (c !== 1 || ee !== 18) begin errors++; $display("FAIL overrun_single_stb: got count %0d edge %0d want 1 18", c, ee); end
      checks++; if (LCH_DAC !== 24'h000040 || RCH_DAC !== 24'h000080) begin
         errors++; $display("FAIL overrun_captured: got %h %h want 000040 000080", LCH_DAC, RCH_DAC);
      end
      do_frame(24'h000001, 24'h000001, 8'd64, 8'd64, 1'b0, e, c, b0, b19);
      checks++; if (overrun !== 1'b1) begin errors++; $display("FAIL overrun_sticky: got %b want 1", overrun); end
   endtask

   initial begin
      test_reset();
      test_unity();
      test_saturation();
      test_rounding();
      test_zero_and_mute();
      test_random();
      test_edge_at_out();
      test_reset_mid_frame();
      test_overrun();
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule

// File: doc/audio_gain_stage.md
Name: audio_gain_stage

Overview:
Stereo per-channel gain and saturation stage placed directly downstream of the codec block. On each LRCK frame boundary it captures the codec's 24-bit ADC samples and scales each one by an unsigned fixed-point gain. It saturates the results to 24-bit signed and presents them as registered DAC-side samples, together with a one-cycle strobe. The multiplier is a serial shift-add unit, so no DSP blocks are needed on iCE40 HX parts.

Parameters:
GAIN_W, 8, gain word width (unsigned).
FRAC, 6, fractional bits of the gain. Unity gain = 2^FRAC = 64.

Ports:
clk  in  1  system clock; the same clock that drives the codec block.
rst  in  1  synchronous active-high reset.
LRCK  in  1  frame clock from the codec, synchronous to clk.
LCH_ADC  in  24  left ADC sample, two's complement.
RCH_ADC  in  24  right ADC sample, two's complement.
gain_l  in  GAIN_W  left gain, unsigned, Q(GAIN_W-FRAC).FRAC.
gain_r  in  GAIN_W  right gain, same format as gain_l.
mute  in  1  when set, both outputs are forced to zero.
LCH_DAC  out  24  scaled left sample.
RCH_DAC  out  24  scaled right sample.
sample_stb  out  1  one-cycle pulse; LCH_DAC and RCH_DAC updated this cycle.
clip_l  out  1  left result saturated; held until the next update.
clip_r  out  1  right result saturated; held until the next update.
busy  out  1  high while a frame is being processed.
overrun  out  1  sticky; a frame edge arrived while busy. Cleared only by rst.

Behaviour:
- Reset: all of the following are 0 from the clock edge that samples rst high:
  - LCH_DAC, RCH_DAC, sample_stb, clip_l, clip_r, busy, overrun.
  - State returns to IDLE.
  - The LRCK history register is set to 1, so LRCK being high right after reset is not treated as an edge.
- Frame edge: a clock edge where LRCK=1 and the previous sampled LRCK=0. Call this edge 0.
- Capture at edge 0, only when state is IDLE:
  - Latch LCH_ADC, RCH_ADC, gain_l, gain_r and mute.
  - Input changes after edge 0 do not affect the frame in flight.
- States and transitions:
  - IDLE: waits for a frame edge. Goes to MUL_L at edge 0.
  - MUL_L: GAIN_W cycles (edges 1..GAIN_W). Processes one gain bit per cycle, LSB first. Accumulator is signed, 24+GAIN_W+1 bits.
  - MUL_R: GAIN_W cycles (edges GAIN_W+1..2*GAIN_W), same operation on the right channel.
  - SAT: one cycle (edge 2*GAIN_W+1). Computes both saturated results.
  - OUT: at edge 2*GAIN_W+2 (edge 18 at default parameters):
    - Registers LCH_DAC, RCH_DAC, clip_l and clip_r.
    - Pulses sample_stb for exactly one cycle.
    - Returns to IDLE.
- busy is high from edge 0 through the OUT cycle. It is low in IDLE.
- Arithmetic:
  - p = sample * gain, computed as signed × unsigned.
  - r = p >>> FRAC, an arithmetic shift (floor toward −inf).
  - If r > 8388607: output 0x7FFFFF and set clip.
  - If r < −8388608: output 0x800000 and set clip.
  - Otherwise output r[23:0] and clear clip.
- mute latched as 1: both outputs are 0, both clip flags are 0, and sample_stb still pulses at the normal time.
- gain = 0: output is 0 with no clip.
- Frame edge while busy:
  - The edge is ignored; the frame in flight completes unchanged.
  - overrun is set to 1.
  - No capture takes place.
- Frame edge in the same cycle as OUT: ignored, and overrun is set. IDLE is only entered on the following cycle.
- rst during processing:
  - Aborts the frame; no sample_stb is generated.
  - Outputs become 0.
  - The next frame edge after rst deasserts is processed normally.
- LRCK held high or low indefinitely: no activity, outputs hold.

Test Plan:
1. gain_l=gain_r=64, L=0x123456, R=0xFEDCBA, LRCK rises → at edge 18 LCH_DAC=0x123456, RCH_DAC=0xFEDCBA, sample_stb high 1 cycle, clip_l=clip_r=0, busy low at edge 19.
2. gain_l=gain_r=128, L=0x500000, R=0xB00000 → LCH_DAC=0x7FFFFF, RCH_DAC=0x800000, clip_l=clip_r=1; next frame with gain 64 and L=0x000010 → 0x000010 and clip_l cleared.
3. Floor rounding: gain_l=32, L=0xFFFFFF → LCH_DAC=0xFFFFFF (−1); gain_r=32, R=0x000003 → RCH_DAC=0x000001; gain_l=255, L=0x7FFFFF → 0x7FFFFF with clip_l=1.
4. gain_l=0 with L=0x400000 → LCH_DAC=0, clip_l=0; mute=1 with gains 64, L=0x123456 → both outputs 0 and sample_stb still pulses at edge 18.
5. Change gain_l to 0 at edge 3 and raise LRCK again at edge 8 (after a low pulse) → result uses the captured gain 64, overrun=1 and stays 1, only one sample_stb.
6. Assert rst at edge 10 of a frame → outputs 0, no sample_stb, busy=0, overrun=0; the following frame with gain 64, L=0x000100 → LCH_DAC=0x000100 at its edge 18.
